// File: rtl/mul_exec_unit.sv
// EX-stage iterative shift-add multiplier: low DATA_W bits of a*b, DATA_W+1 cycle latency.
// Stalls the pipeline from the start cycle through the last BUSY cycle; flush aborts at any time.
module mul_exec_unit #(
  parameter int         DATA_W   = 64,
  parameter logic [3:0] MUL_CODE = 4'd8
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              valid_in,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              stall
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] a_sh;
  logic [DATA_W-1:0] b_sh;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_sum;
  logic [CNT_W-1:0]  cnt;
  logic              start;
  logic              last_iter;

  assign start     = valid_in && (alu_control == MUL_CODE) && !flush && (state == IDLE);
  assign last_iter = (cnt == CNT_W'(1));
  assign acc_sum   = b_sh[0] ? (acc + a_sh) : acc;

  assign busy         = (state == BUSY);
  assign stall        = start || (state == BUSY);
  assign result_valid = (state == DONE) && !flush;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = BUSY;
      end
      BUSY: begin
        if (flush)          state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The final partial product is folded in on the same edge that writes result.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= operand_a;
            b_sh <= operand_b;
            acc  <= '0;
            cnt  <= CNT_W'(DATA_W);
          end
        end
        BUSY: begin
          if (!flush) begin
            acc  <= acc_sum;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - CNT_W'(1);
            if (last_iter) result <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
